seq_div_16by8: RTL
==================

Name: seq_div_16by8

Overview:
- Sequential restoring divider: divides a 2*DW-bit unsigned dividend by a DW-bit unsigned divisor.
- Produces a 2*DW-bit quotient and a DW-bit remainder, one quotient bit per clock.
- Inverse companion to the combinational vedic multiplier tree. Shares its operand/product widths (DW=8: 16-bit by 8-bit), so a product can be fed straight back for checking.
- Start/busy/done handshake.

Parameters:
- DW, 8, divisor and remainder width; dividend and quotient are 2*DW bits.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  2*DW  dividend, captured when start is accepted
- b  input  DW  divisor, captured when start is accepted
- busy  output  1  division in progress
- done  output  1  one-cycle pulse: q/r/dz valid
- q  output  2*DW  quotient, held until next accepted start
- r  output  DW  remainder, held until next accepted start
- dz  output  1  divide-by-zero flag for the current result

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; busy=0, done=0, q=0, r=0, dz=0; iteration counter=0.
  - Takes effect immediately, including mid-division; the partial result is discarded.
- States:
  - IDLE: busy=0. On start=1 at edge E0, capture a and b. Then:
    - b==0: go to ZERO.
    - otherwise: go to CALC, with dividend shift register=a, partial remainder (DW+1 bits)=0, count=2*DW-1.
  - CALC: busy=1. Each edge:
    - pr = {pr[DW-1:0], sr[2*DW-1]}
    - sr = sr<<1
    - if pr >= b: pr -= b, sr[0]=1; else sr[0]=0
    - count-- ; after the iteration with count==0, go to IDLE.
  - ZERO: busy=1 for exactly one cycle, then IDLE.
- Completion:
  - Leaving CALC or ZERO registers q, r and dz and sets done=1 for one cycle.
  - CALC exit: q=sr, r=pr[DW-1:0], dz=0.
  - ZERO exit: q=all ones, r=a[DW-1:0], dz=1.
- Latency, start accepted at E0 (normal divide):
  - Iterations occur at E1..E2*DW.
  - busy high after E0, low after E2*DW.
  - done high between E2*DW and E2*DW+1.
  - 16 clocks at DW=8.
- Latency, divide-by-zero: done high between E1 and E2.
- Handshake:
  - start while busy=1 is ignored; inputs are not re-captured.
  - start in the done cycle (busy=0) is accepted: done clears next cycle and a new operation begins back to back.
- Outputs q, r, dz keep the previous result during a new operation until its completion edge.
- Invariants when dz=0: q*b + r == a; r < b.
- Arithmetic is unsigned throughout. The compare/subtract uses DW+1 bits so no bit is lost when the shifted remainder exceeds 2^DW-1.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if b!=0 and a < b (zero-extended compare), go directly to a one-cycle FAST state. Its exit sets q=0, r=a[DW-1:0], dz=0. Timing is the same as ZERO: done between E1 and E2.
- Not defined: no FAST state; a < b takes the full 2*DW-cycle CALC path with the identical numeric result.

Test Plan:
- Reset mid-op: assert rst_n=0 at iteration 5 -> busy, done, q, r, dz all 0 immediately. After release, 0x0100/0x10 -> q=0x0010, r=0x00.
- Basic: a=1000, b=7, start at E0 -> done pulse at E16 only, q=142, r=6, dz=0; busy high for exactly 16 cycles.
- Extremes:
  - 0xFFFF/0x01 -> q=0xFFFF, r=0x00.
  - 0xFFFF/0xFF -> q=0x0101, r=0x00.
  - 0xFFFE/0xFF -> q=0x0100, r=0xFE.
- Divide-by-zero: a=0x1234, b=0 -> done at E1, q=0xFFFF, r=0x34, dz=1.
- Handshake:
  - start re-pulsed with a=5, b=1 during busy -> ignored; first result 1000/7 unchanged.
  - start in the done cycle with a=0x00FF, b=0x10 -> accepted; q=0x000F, r=0x0F 16 cycles later.
- Early exit: a=5, b=9 -> q=0, r=5, dz=0. With DIV_EARLY_EXIT_EN done comes at E1; without it, at E16.
- Random: 10k random a and b!=0 -> q*b + r == a and r < b; compare against the multiplier output.

Source files
------------

// File: rtl/seq_div_16by8.sv
// seq_div_16by8: sequential restoring divider, 2*DW-bit dividend by DW-bit divisor, one quotient bit per clock.
// Optional DIV_EARLY_EXIT_EN: one-cycle FAST path when the dividend is smaller than the divisor.
module seq_div_16by8 #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*DW-1:0] a,
  input  logic [DW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] q,
  output logic [DW-1:0]   r,
  output logic            dz
);
  localparam int CW = $clog2(2*DW);
`ifdef DIV_EARLY_EXIT_EN
  typedef enum logic [1:0] {IDLE, CALC, ZERO, FAST} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, ZERO} state_t;
`endif
  state_t state, state_n;
  logic [2*DW-1:0] sr, sr_n;
  logic [DW:0] pr, pr_sh, pr_n;
  logic [DW-1:0] dv;
  logic [CW-1:0] cnt;
  logic ge;
  // remainder path is DW+1 bits wide so the shifted-in bit never overflows the compare
  assign pr_sh = {pr[DW-1:0], sr[2*DW-1]};
  assign ge    = pr_sh >= {1'b0, dv};
  assign pr_n  = ge ? pr_sh - {1'b0, dv} : pr_sh;
  assign sr_n  = {sr[2*DW-2:0], ge};
  assign busy  = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) begin
        state_n = (b == '0) ? ZERO : CALC;
`ifdef DIV_EARLY_EXIT_EN
        if (b != '0 && a < {{DW{1'b0}}, b}) state_n = FAST;
`endif
      end
      CALC: state_n = (cnt == '0) ? IDLE : CALC;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      pr   <= '0;
      dv   <= '0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      dz   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        sr  <= a;
        dv  <= b;
        pr  <= '0;
        cnt <= CW'(2*DW-1);
      end else if (state == CALC) begin
        sr  <= sr_n;
        pr  <= pr_n;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          q    <= sr_n;
          r    <= pr_n[DW-1:0];
          dz   <= 1'b0;
          done <= 1'b1;
        end
      end else if (state == ZERO) begin
        q    <= '1;
        r    <= sr[DW-1:0];
        dz   <= 1'b1;
        done <= 1'b1;
      end
`ifdef DIV_EARLY_EXIT_EN
      else if (state == FAST) begin
        q    <= '0;
        r    <= sr[DW-1:0];
        dz   <= 1'b0;
        done <= 1'b1;
      end
`endif
    end
  end
endmodule
